// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 style memory access unit: FSM states,
// r_w / data_size encodings and the byte-lane count helper.
package lc3_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} mau_state_t;

  localparam logic R_W_WRITE = 1'b1;
  localparam logic R_W_READ  = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;

  function automatic int num_lanes(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word storage with per-byte write enables and a
// registered read port that holds its value until the next read.
module mem_array
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AW     = 15
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [num_lanes(DATA_W)-1:0]   i_be,
  input  logic [AW-1:0]                  i_addr,
  input  logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W-1:0]              o_rdata
);
  localparam int NB = num_lanes(DATA_W);

  logic [NB-1:0][7:0] r_mem [2**AW];
  logic [DATA_W-1:0]  r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < NB; b++)
          if (i_be[b]) r_mem[i_addr][b] <= i_wdata[8*b +: 8];
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR front end to mem_array: multi-cycle byte/word accesses with a
// programmable wait count, READY pulse and sticky unaligned-word flag.
module mem_access_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              load_mar,
  input  logic              load_mdr,
  input  logic              gate_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ready,
  output logic              unaligned
);
  localparam int NB = num_lanes(DATA_W);
  localparam int LB = $clog2(NB);
  localparam int AW = ADDR_W - LB;

  mau_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [3:0]        r_cnt;
  logic              r_rw, r_size, r_unal;
  logic [LB-1:0]     r_lane;

  logic [LB-1:0]     w_mar_lane;
  logic              w_start, w_mis, w_last, w_mem_en, w_mem_we;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_rdata;
  logic [7:0]        w_byte;

  assign w_mar_lane = r_mar[LB-1:0];
  assign w_start    = (r_state == IDLE) && mio_en;
  assign w_mis      = (data_size == SIZE_WORD) && (w_mar_lane != '0);
  assign w_last     = (r_state == BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mio_en) w_state_nxt = w_mis ? DONE : BUSY;
      BUSY:    if (r_cnt == 4'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = mio_en ? HOLD : IDLE;
      HOLD:    if (!mio_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_rw    <= R_W_READ;
      r_size  <= SIZE_BYTE;
      r_lane  <= '0;
      r_unal  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_rw   <= r_w;
        r_size <= data_size;
        r_lane <= w_mar_lane;
        r_unal <= w_mis;
        r_cnt  <= 4'(WAIT_CYCLES);
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Access start takes the old MAR even if load_mar arrives on the same edge.
      if (r_state == IDLE && load_mar) r_mar <= bus_in[ADDR_W-1:0];
      if (r_state == IDLE && load_mdr && !mio_en)
        r_mdr <= (data_size == SIZE_BYTE) ? {NB{bus_in[7:0]}} : bus_in;
      else if (w_last && r_rw == R_W_READ)
        r_mdr <= w_rdata;
    end
  end

  // Read is issued at start so registered data is ready by the last BUSY edge;
  // writes commit on that last edge so a reset inside BUSY leaves storage alone.
  assign w_mem_we = w_last && (r_rw == R_W_WRITE);
  assign w_mem_en = (w_start && !w_mis && r_w == R_W_READ) || w_mem_we;
  assign w_be     = (r_size == SIZE_WORD) ? '1 : (NB'(1) << r_lane);

  mem_array #(.DATA_W(DATA_W), .AW(AW)) u_mem (
    .clk    (clk),
    .i_en   (w_mem_en),
    .i_we   (w_mem_we),
    .i_be   (w_be),
    .i_addr (r_mar[ADDR_W-1:LB]),
    .i_wdata(r_mdr),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_byte  = r_mdr[{w_mar_lane, 3'b000} +: 8];
    bus_out = '0;
    if (gate_mdr)
      bus_out = (data_size == SIZE_WORD) ? r_mdr : {{(DATA_W-8){w_byte[7]}}, w_byte};
  end

  assign bus_oe    = gate_mdr;
  assign ready     = (r_state == DONE);
  assign unaligned = r_unal;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: a 16-bit/2-wait unit checked against a byte-addressed memory model,
// plus a 32-bit/0-wait unit for lane-3 sign extension and minimum latency.
module tb_mem_access_unit;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] a_bus_in, a_bus_out;
  logic a_load_mar, a_load_mdr, a_gate, a_mio, a_rw, a_size, a_oe, a_ready, a_unal;
  logic [31:0] b_bus_in, b_bus_out;
  logic b_load_mar, b_load_mdr, b_gate, b_mio, b_rw, b_size, b_oe, b_ready, b_unal;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(W)) u_a (
    .clk(clk), .reset(reset), .bus_in(a_bus_in), .load_mar(a_load_mar),
    .load_mdr(a_load_mdr), .gate_mdr(a_gate), .mio_en(a_mio), .r_w(a_rw),
    .data_size(a_size), .bus_out(a_bus_out), .bus_oe(a_oe), .ready(a_ready),
    .unaligned(a_unal));

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .bus_in(b_bus_in), .load_mar(b_load_mar),
    .load_mdr(b_load_mdr), .gate_mdr(b_gate), .mio_en(b_mio), .r_w(b_rw),
    .data_size(b_size), .bus_out(b_bus_out), .bus_oe(b_oe), .ready(b_ready),
    .unaligned(b_unal));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed storage, MAR/MDR and the sticky flag.
  logic [7:0]  mmem [logic [15:0]];
  logic [15:0] m_mar, m_mdr;
  logic        m_unal;

  function automatic logic [15:0] mrd(input logic [15:0] a);
    return {mmem[{a[15:1], 1'b1}], mmem[{a[15:1], 1'b0}]};
  endfunction

  function automatic logic [15:0] m_view(input logic sz);
    logic [7:0] b;
    b = m_mar[0] ? m_mdr[15:8] : m_mdr[7:0];
    return sz ? m_mdr : {{8{b[7]}}, b};
  endfunction

  task automatic set_mar(input logic [15:0] a);
    @(negedge clk); a_bus_in = a; a_load_mar = 1'b1;
    @(negedge clk); a_load_mar = 1'b0;
    m_mar = a;
  endtask

  task automatic set_mdr(input logic [15:0] d, input logic sz);
    @(negedge clk); a_bus_in = d; a_size = sz; a_load_mdr = 1'b1;
    @(negedge clk); a_load_mdr = 1'b0;
    m_mdr = sz ? d : {2{d[7:0]}};
  endtask

  // Latency counted in rising edges after the one that samples mio_en.
  task automatic access(input string tag, input logic rw, input logic sz,
                        input logic lm, input logic [15:0] nm, output logic [15:0] v);
    int k;
    logic [15:0] a;
    bit mis;
    a = m_mar;
    mis = sz && a[0];
    @(negedge clk); a_rw = rw; a_size = sz; a_gate = 1'b1; a_mio = 1'b1;
    a_load_mar = lm; a_bus_in = nm;
    @(posedge clk);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      a_load_mar = 1'b0;
      if (a_ready === 1'b1) break;
    end
    v = a_bus_out;
    if (mis) m_unal = 1'b1;
    else begin
      m_unal = 1'b0;
      if (!rw) m_mdr = mrd(a);
      else if (sz) begin
        mmem[{a[15:1], 1'b0}] = m_mdr[7:0];
        mmem[{a[15:1], 1'b1}] = m_mdr[15:8];
      end else mmem[a] = a[0] ? m_mdr[15:8] : m_mdr[7:0];
    end
    if (lm) m_mar = nm;
    chk({tag, ".lat"}, 64'(k), mis ? 64'd0 : 64'(W + 1));
    chk({tag, ".unal"}, 64'(a_unal), 64'(m_unal));
    chk({tag, ".bus"}, 64'(v), 64'(m_view(sz)));
    a_mio = 1'b0;
    @(negedge clk);
    chk({tag, ".pulse"}, 64'(a_ready), 64'd0);
    a_gate = 1'b0;
  endtask

  task automatic b_access(input logic rw, output int kout);
    int k;
    @(negedge clk); b_rw = rw; b_size = 1'b1; b_mio = 1'b1;
    @(posedge clk);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_ready === 1'b1) break;
    end
    b_mio = 1'b0;
    kout = k;
  endtask

  initial begin
    logic [15:0] v;
    int pulses, kb;
    reset = 1'b1;
    {a_load_mar, a_load_mdr, a_gate, a_mio, a_rw, a_size} = '0;
    {b_load_mar, b_load_mdr, b_gate, b_mio, b_rw, b_size} = '0;
    a_bus_in = '0; b_bus_in = '0;
    m_mar = '0; m_mdr = '0; m_unal = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst.ready", 64'(a_ready), 0);
    chk("rst.unal", 64'(a_unal), 0);
    chk("rst.oe", 64'(a_oe), 0);
    chk("rst.bus", 64'(a_bus_out), 0);
    a_gate = 1'b1; a_size = 1'b1; #1;
    chk("rst.mdr", 64'(a_bus_out), 0);
    a_gate = 1'b0;
    reset = 1'b0;

    set_mar(16'h0040); set_mdr(16'hBEEF, 1'b1); access("wr40", 1, 1, 0, 0, v);
    set_mdr(16'h0000, 1'b1); access("rd40", 0, 1, 0, 0, v);
    chk("tp.beef", 64'(v), 64'hBEEF);
    set_mar(16'h0041); set_mdr(16'h007F, 1'b0); access("wrb41", 1, 0, 0, 0, v);
    set_mar(16'h0040); access("rd40b", 0, 1, 0, 0, v);
    chk("tp.7fef", 64'(v), 64'h7FEF);
    set_mar(16'h0041); access("rdb41", 0, 0, 0, 0, v);
    chk("tp.007f", 64'(v), 64'h007F);
    set_mar(16'h0040); access("rdb40", 0, 0, 0, 0, v);
    chk("tp.ffef", 64'(v), 64'hFFEF);

    set_mar(16'h0042); set_mdr(16'h1111, 1'b1); access("wr42", 1, 1, 0, 0, v);
    set_mdr(16'hABCD, 1'b1); set_mar(16'h0043); access("unaw", 1, 1, 0, 0, v);
    chk("una.mdr", 64'(v), 64'hABCD);
    access("unar", 0, 1, 0, 0, v);
    chk("una.flag", 64'(a_unal), 1);
    set_mar(16'h0042); access("aft", 0, 1, 0, 0, v);
    chk("una.store", 64'(v), 64'h1111);
    chk("una.clr", 64'(a_unal), 0);

    // load_mar together with mio_en: this access uses 0x40, the next uses 0x42
    set_mar(16'h0040); access("sim", 0, 1, 1, 16'h0042, v);
    chk("sim.old", 64'(v), 64'h7FEF);
    access("sim2", 0, 1, 0, 0, v);
    chk("sim.new", 64'(v), 64'h1111);

    set_mar(16'h0040);
    @(negedge clk); a_rw = 1'b0; a_size = 1'b1; a_mio = 1'b1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_ready) pulses++;
      a_load_mar = (i == 0); a_bus_in = 16'h0041;
    end
    a_mio = 1'b0; a_load_mar = 1'b0;
    @(negedge clk);
    m_mdr = mrd(16'h0040);
    chk("hold.pulses", 64'(pulses), 1);
    a_gate = 1'b1; a_size = 1'b0; #1;
    chk("hold.mar", 64'(a_bus_out), 64'(m_view(1'b0)));
    chk("hold.ffef", 64'(a_bus_out), 64'hFFEF);
    a_gate = 1'b0;

    set_mar(16'h0010); set_mdr(16'h5555, 1'b1); access("wr10", 1, 1, 0, 0, v);
    set_mdr(16'h1234, 1'b1);
    @(negedge clk); a_rw = 1'b1; a_size = 1'b1; a_mio = 1'b1;
    @(negedge clk);
    reset = 1'b1; a_mio = 1'b0; #1;
    chk("abort.oe", 64'(a_oe), 0);
    chk("abort.ready", 64'(a_ready), 0);
    chk("abort.unal", 64'(a_unal), 0);
    a_gate = 1'b1; #1;
    chk("abort.bus", 64'(a_bus_out), 0);
    a_gate = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (a_ready) pulses++; end
    chk("abort.noready", 64'(pulses), 0);
    m_mar = '0; m_mdr = '0; m_unal = 1'b0;
    set_mar(16'h0010); access("rd10", 0, 1, 0, 0, v);
    chk("abort.keep", 64'(v), 64'h5555);

    for (int w = 0; w < 8; w++) begin
      set_mar(16'h0100 + 16'(2 * w)); set_mdr(16'($urandom), 1'b1);
      access("pre", 1, 1, 0, 0, v);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: set_mar(16'h0100 + 16'($urandom_range(0, 15)));
        1: set_mdr(16'($urandom), 1'($urandom));
        default: access("rnd", 1'($urandom), 1'($urandom), 0, 0, v);
      endcase
    end

    @(negedge clk); b_bus_in = 32'h20; b_load_mar = 1'b1;
    @(negedge clk); b_load_mar = 1'b0; b_bus_in = 32'h8A123456; b_size = 1'b1; b_load_mdr = 1'b1;
    @(negedge clk); b_load_mdr = 1'b0;
    b_access(1'b1, kb);
    chk("b.wlat", 64'(kb), 1);
    @(negedge clk); b_bus_in = 32'h0; b_load_mdr = 1'b1;
    @(negedge clk); b_load_mdr = 1'b0;
    b_access(1'b0, kb);
    chk("b.rlat", 64'(kb), 1);
    b_gate = 1'b1; b_size = 1'b1; #1;
    chk("b.word", 64'(b_bus_out), 64'h8A123456);
    @(negedge clk); b_bus_in = 32'h23; b_load_mar = 1'b1;
    @(negedge clk); b_load_mar = 1'b0; b_size = 1'b0; #1;
    chk("b.lane3", 64'(b_bus_out), 64'hFFFFFF8A);
    @(negedge clk); b_bus_in = 32'h22; b_load_mar = 1'b1;
    @(negedge clk); b_load_mar = 1'b0; #1;
    chk("b.lane2", 64'(b_bus_out), 64'h00000012);
    b_gate = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
